axi_lite_arbiter: RTL and testbench

- Two-master, one-slave AXI-lite arbiter in front of the shared peripheral/memory bus (CLINT, UART, SRAM behind the crossbar).
- Master 0 is the IFU; master 1 is the LSU.
- Grants one master at a time and routes that master's channels to the slave until its transaction completes. Exactly one transaction is outstanding.
- Round-robin fairness, so neither the IFU nor the LSU starves.

---
 rtl/axi_lite_arbiter_pkg.sv | 21 ++
 rtl/axi_lite_arbiter_pick2.sv | 27 ++
 rtl/axi_lite_arbiter.sv | 128 ++++++++++++
 tb/tb_axi_lite_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_arbiter_pkg.sv
// Shared types and constants for the two-master AXI-lite arbiter.
// Fixed-priority tie-break is selected with the AXI_ARB_FIXED_PRIO_EN macro.
package axi_lite_arbiter_pkg;

  localparam int CPU_WIDTH = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_RD   = 2'd1,
    ARB_WR   = 2'd2
  } arb_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Place a single-bit handshake signal into the slot of the granted master.
  function automatic logic [1:0] to_slot(input logic en, input logic g);
    return en ? (g ? 2'b10 : 2'b01) : 2'b00;
  endfunction

endpackage

// File: rtl/axi_lite_arbiter_pick2.sv
// Two-way winner selection: round-robin on last-served master, or fixed
// priority to m1 (LSU) when AXI_ARB_FIXED_PRIO_EN is defined.
module axi_lite_arbiter_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       win
);

`ifdef AXI_ARB_FIXED_PRIO_EN
  wire unused_last = last;

  always_comb begin
    win = req[1];
  end
`else
  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    win = 1'b0;
    case (req)
      2'b10:   win = 1'b1;
      2'b11:   win = ~last;
      default: win = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/axi_lite_arbiter.sv
// Two-master (IFU=m0, LSU=m1), one-slave AXI-lite arbiter, one transaction
// outstanding. Define AXI_ARB_FIXED_PRIO_EN for fixed m1 priority on ties.
module axi_lite_arbiter
  import axi_lite_arbiter_pkg::*;
#(
  parameter int DATA_W = CPU_WIDTH,
  parameter int STRB_W = CPU_WIDTH / 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  // master side, master i occupies slice i
  input  logic [2*DATA_W-1:0]   m_awaddr,
  input  logic [1:0]            m_awvalid,
  output logic [1:0]            m_awready,
  input  logic [2*DATA_W-1:0]   m_wdata,
  input  logic [2*STRB_W-1:0]   m_wstrb,
  input  logic [1:0]            m_wvalid,
  output logic [1:0]            m_wready,
  output logic [3:0]            m_bresp,
  output logic [1:0]            m_bvalid,
  input  logic [1:0]            m_bready,
  input  logic [2*DATA_W-1:0]   m_araddr,
  input  logic [1:0]            m_arvalid,
  output logic [1:0]            m_arready,
  output logic [2*DATA_W-1:0]   m_rdata,
  output logic [3:0]            m_rresp,
  output logic [1:0]            m_rvalid,
  input  logic [1:0]            m_rready,
  // slave side
  output logic [DATA_W-1:0]     s_awaddr,
  output logic                  s_awvalid,
  input  logic                  s_awready,
  output logic [DATA_W-1:0]     s_wdata,
  output logic [STRB_W-1:0]     s_wstrb,
  output logic                  s_wvalid,
  input  logic                  s_wready,
  input  logic [1:0]            s_bresp,
  input  logic                  s_bvalid,
  output logic                  s_bready,
  output logic [DATA_W-1:0]     s_araddr,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  logic [DATA_W-1:0]     s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rvalid,
  output logic                  s_rready
);

  arb_state_t state;
  logic       gnt;
  logic       last;
  logic       aw_done;
  logic       w_done;
  logic [1:0] req;
  logic       win;
  logic       rd_st;
  logic       wr_st;

  assign req   = m_arvalid | m_awvalid;
  assign rd_st = (state == ARB_RD);
  assign wr_st = (state == ARB_WR);

  axi_lite_arbiter_pick2 u_pick (
    .req  (req),
    .last (last),
    .win  (win)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ARB_IDLE;
      gnt     <= 1'b0;
      last    <= 1'b1;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|req) begin
            gnt   <= win;
            state <= m_awvalid[win] ? ARB_WR : ARB_RD;
          end
        end
        ARB_RD: begin
          if (s_rvalid && s_rready) begin
            state <= ARB_IDLE;
            last  <= gnt;
          end
        end
        ARB_WR: begin
          if (s_awvalid && s_awready) aw_done <= 1'b1;
          if (s_wvalid && s_wready)   w_done  <= 1'b1;
          if (s_bvalid && s_bready) begin
            state   <= ARB_IDLE;
            last    <= gnt;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Payloads are muxed unconditionally; only the valid/ready pairs are gated.
  assign s_araddr = gnt ? m_araddr[2*DATA_W-1:DATA_W] : m_araddr[DATA_W-1:0];
  assign s_awaddr = gnt ? m_awaddr[2*DATA_W-1:DATA_W] : m_awaddr[DATA_W-1:0];
  assign s_wdata  = gnt ? m_wdata[2*DATA_W-1:DATA_W]  : m_wdata[DATA_W-1:0];
  assign s_wstrb  = gnt ? m_wstrb[2*STRB_W-1:STRB_W]  : m_wstrb[STRB_W-1:0];

  assign s_arvalid = rd_st & m_arvalid[gnt];
  assign s_rready  = rd_st & m_rready[gnt];
  assign m_arready = to_slot(rd_st & s_arready, gnt);
  assign m_rvalid  = to_slot(rd_st & s_rvalid, gnt);
  assign m_rdata   = {2{s_rdata}};
  assign m_rresp   = {2{s_rresp}};

  // A completed AW or W channel stays quiet until B closes the transaction.
  assign s_awvalid = wr_st & ~aw_done & m_awvalid[gnt];
  assign s_wvalid  = wr_st & ~w_done & m_wvalid[gnt];
  assign s_bready  = wr_st & m_bready[gnt];
  assign m_awready = to_slot(wr_st & ~aw_done & s_awready, gnt);
  assign m_wready  = to_slot(wr_st & ~w_done & s_wready, gnt);
  assign m_bvalid  = to_slot(wr_st & s_bvalid, gnt);
  assign m_bresp   = {2{s_bresp}};

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter: arbitration table plus multi-cycle
// sequences (latency, write ordering, stalls, async reset).
module tb_axi_lite_arbiter;
  import axi_lite_arbiter_pkg::*;

  localparam int DW = 32;
  localparam int SW = 4;
  localparam logic [31:0] AR0 = 32'ha000_2000, AR1 = 32'hb000_1000;
  localparam logic [31:0] AW0 = 32'ha000_3000, AW1 = 32'hb000_3000;
`ifdef AXI_ARB_FIXED_PRIO_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [2*DW-1:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2*SW-1:0] m_wstrb;
  logic [1:0] m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [1:0] m_arvalid, m_arready, m_rvalid, m_rready;
  logic [3:0] m_bresp, m_rresp;
  logic [DW-1:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [SW-1:0] s_wstrb;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0] s_bresp, s_rresp;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  axi_lite_arbiter #(.DATA_W(DW), .STRB_W(SW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  typedef struct {
    logic [1:0] ar;
    logic [1:0] aw;
    logic       m_rr;
    logic       m_fp;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  function automatic logic [14:0] hs_bundle();
    return {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready,
            m_arready, m_awready, m_wready, m_rvalid, m_bvalid};
  endfunction

  task automatic clear_drive();
    m_awvalid = '0; m_wvalid = '0; m_arvalid = '0;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_arready = 0; s_rvalid = 0;
    s_bresp = RESP_OKAY; s_rresp = RESP_OKAY;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_drive();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  // Acts as the slave for one transaction; reports which master was served.
  task automatic serve(output logic m, output logic wr, output int lat, output bit ok);
    ok = 0; m = 0; wr = 0; lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (s_arvalid || s_awvalid) begin
        lat = i; ok = 1; break;
      end
    end
    if (!ok) return;
    if (s_awvalid) begin
      wr = 1; m = (s_awaddr == AW1);
      s_awready = 1; s_wready = 1;
      @(negedge clk);
      m_awvalid[m] = 0; m_wvalid[m] = 0; s_awready = 0; s_wready = 0;
      s_bvalid = 1; s_bresp = RESP_OKAY;
      @(negedge clk);
      s_bvalid = 0;
    end else begin
      m = (s_araddr == AR1);
      s_arready = 1;
      @(negedge clk);
      m_arvalid[m] = 0; s_arready = 0;
      s_rvalid = 1; s_rdata = 32'h5a5a_0000;
      @(negedge clk);
      s_rvalid = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic m, wr;
    int lat, n;
    bit ok, bad, found;
    logic exp_m;

    // m0 tie-break sequence under round-robin starts with last=1
    vecs[0] = '{2'b01, 2'b00, 1'b0, 1'b0};
    vecs[1] = '{2'b10, 2'b00, 1'b1, 1'b1};
    vecs[2] = '{2'b11, 2'b00, 1'b0, 1'b1};
    vecs[3] = '{2'b11, 2'b00, 1'b1, 1'b1};
    vecs[4] = '{2'b01, 2'b10, 1'b0, 1'b1};
    vecs[5] = '{2'b01, 2'b10, 1'b1, 1'b1};
    vecs[6] = '{2'b01, 2'b01, 1'b0, 1'b0};
    vecs[7] = '{2'b00, 2'b11, 1'b1, 1'b1};
    vecs[8] = '{2'b00, 2'b11, 1'b0, 1'b1};

    m_awaddr = {AW1, AW0};
    m_araddr = {AR1, AR0};
    m_wdata  = {32'h1111_1111, 32'h0000_0000};
    m_wstrb  = {4'hf, 4'h3};
    m_bready = 2'b11;
    m_rready = 2'b11;
    s_rdata  = '0;
    rst_n    = 0;
    clear_drive();

    // Reset with every request and slave ready high: nothing may pass.
    m_arvalid = 2'b11; m_awvalid = 2'b11; m_wvalid = 2'b11;
    s_arready = 1; s_awready = 1; s_wready = 1; s_rvalid = 1; s_bvalid = 1;
    repeat (2) @(negedge clk);
    check("reset_handshakes", hs_bundle(), 0);
    clear_drive();
    @(negedge clk);
    rst_n = 1;

    // m0 read of 0xa0002000 alone
    m_arvalid = 2'b01;
    #1 check("rd_idle_no_arvalid", s_arvalid, 0);
    @(negedge clk);
    check("rd_arvalid_t1", {s_arvalid, s_araddr}, {1'b1, AR0});
    s_arready = 1;
    #1 check("rd_arready_m0", m_arready, 2'b01);
    @(negedge clk);
    m_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rdata = 32'h1234_5678; s_rresp = RESP_OKAY;
    #1 check("rd_rvalid_m0_only", m_rvalid, 2'b01);
    check("rd_rdata_slice0", m_rdata[31:0], 32'h1234_5678);
    check("rd_rready", s_rready, 1);
    @(negedge clk);
    s_rvalid = 0;
    check("rd_back_idle", {s_arvalid, s_rready, m_rvalid}, 0);

    // Arbitration table
    do_reset();
    foreach (vecs[i]) begin
      m_arvalid = vecs[i].ar; m_awvalid = vecs[i].aw; m_wvalid = vecs[i].aw;
      exp_m = FP ? vecs[i].m_fp : vecs[i].m_rr;
      serve(m, wr, lat, ok);
      check($sformatf("vec%0d_served", i), ok, 1);
      check($sformatf("vec%0d_master", i), m, exp_m);
      check($sformatf("vec%0d_write", i), wr, vecs[i].aw[exp_m]);
      check($sformatf("vec%0d_latency", i), lat, 1);
      m_arvalid = 0; m_awvalid = 0; m_wvalid = 0;
    end

    // m1 write with W three cycles before AW
    do_reset();
    m_wdata[63:32] = 32'hdead_beef;
    m_wvalid = 2'b10;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (s_wvalid || s_awvalid) bad = 1;
    end
    check("w_only_no_grant", bad, 0);
    m_awvalid = 2'b10; s_wready = 1; s_awready = 0;
    @(negedge clk);
    check("wr_both_valid", {s_awvalid, s_wvalid}, 2'b11);
    check("wr_wdata_m1", {s_wdata, s_wstrb}, {32'hdead_beef, 4'hf});
    check("wr_wready_m1", m_wready, 2'b10);
    @(negedge clk);
    check("wr_w_masked", {s_wvalid, m_wready, s_awvalid}, {1'b0, 2'b00, 1'b1});
    s_awready = 1;
    #1 check("wr_awready_m1", m_awready, 2'b10);
    @(negedge clk);
    m_awvalid = 0; m_wvalid = 0; s_awready = 0; s_wready = 0;
    s_bvalid = 1; s_bresp = RESP_OKAY;
    #1 check("wr_bvalid_m1_only", {m_bvalid, s_bready}, {2'b10, 1'b1});
    check("wr_bresp_m1", m_bresp[3:2], RESP_OKAY);
    @(negedge clk);
    s_bvalid = 0;
    check("wr_back_idle", hs_bundle(), 0);

    // m0 holds AW and AR together: write first
    do_reset();
    m_awvalid = 2'b01; m_wvalid = 2'b01; m_arvalid = 2'b01;
    @(negedge clk);
    check("aw_ar_write_first", {s_awvalid, s_arvalid}, 2'b10);
    s_awready = 1; s_wready = 1;
    @(negedge clk);
    bad = s_arvalid;
    m_awvalid = 0; m_wvalid = 0; s_awready = 0; s_wready = 0; s_bvalid = 1;
    @(negedge clk);
    bad = bad | s_arvalid;
    s_bvalid = 0;
    check("aw_ar_no_read_during_write", bad, 0);
    @(negedge clk);
    check("aw_ar_read_after", {s_arvalid, s_araddr}, {1'b1, AR0});
    s_arready = 1;
    @(negedge clk);
    m_arvalid = 0; s_arready = 0; s_rvalid = 1;
    @(negedge clk);
    s_rvalid = 0;

    // Slave stalls R for 10 cycles while m1 waits
    do_reset();
    m_arvalid = 2'b01;
    @(negedge clk);
    s_arready = 1;
    @(negedge clk);
    s_arready = 0; m_arvalid = 2'b10;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (m_arready[1] || m_rvalid[1] || m_awready[1] || m_wready[1] || m_bvalid[1] || s_arvalid)
        bad = 1;
    end
    check("stall_m1_quiet", bad, 0);
    s_rvalid = 1;
    @(negedge clk);
    s_rvalid = 0;
    found = 0; n = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (s_arvalid && s_araddr == AR1) begin
        found = 1; n = i; break;
      end
    end
    check("stall_m1_granted", found, 1);
    check("stall_m1_within_2", n inside {[1:2]}, 1);
    s_arready = 1;
    @(negedge clk);
    m_arvalid = 0; s_arready = 0; s_rvalid = 1;
    @(negedge clk);
    s_rvalid = 0;

    // Async reset in WR after the AW handshake
    do_reset();
    m_awvalid = 2'b01; m_wvalid = 2'b01; s_awready = 1; s_wready = 0;
    @(negedge clk);
    check("rst_wr_start", {s_awvalid, s_wvalid}, 2'b11);
    @(negedge clk);
    check("rst_aw_done_mask", {s_awvalid, s_wvalid}, 2'b01);
    s_awready = 0;
    #2 rst_n = 0;
    #1 check("rst_async_outputs", hs_bundle(), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    serve(m, wr, lat, ok);
    check("rst_fresh_write", {ok, m, wr}, {1'b1, 1'b0, 1'b1});

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
